// File: rtl/register_stack_if.sv
// Bus-side view of the register stack: command/data inputs and status outputs.
// The master drives commands and data; the slave (the stack) drives the status.
interface register_stack_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             i_push;
    logic             i_pop;
    logic             i_load_enable;
    logic [WIDTH-1:0] i_data;
    logic [WIDTH-1:0] o_top;
    logic [CW-1:0]    o_count;
    logic             o_empty;
    logic             o_full;
    logic             o_overflow;
    logic             o_underflow;

    modport master (
        output i_push, i_pop, i_load_enable, i_data,
        input  o_top, o_count, o_empty, o_full, o_overflow, o_underflow
    );

    modport slave (
        input  i_push, i_pop, i_load_enable, i_data,
        output o_top, o_count, o_empty, o_full, o_overflow, o_underflow
    );
endinterface

// File: rtl/register_stack.sv
// LIFO register stack with push, pop, replace-top and overwrite-top commands,
// a registered top-of-stack copy, occupancy status and sticky error flags.
module register_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    register_stack_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] entries [DEPTH];
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] top_q;
    logic             overflow;
    logic             underflow;

    logic [CW-1:0]    next_count;
    logic [WIDTH-1:0] next_top;
    logic             wr_en;
    logic [AW-1:0]    wr_idx;
    logic             set_overflow;
    logic             set_underflow;

    // Indices wrap modulo 2**AW, which stays exact for every count in 0..DEPTH
    // where the index is actually used.
    logic [AW-1:0]    push_idx;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    below_idx;

    assign push_idx  = count[AW-1:0];
    assign top_idx   = count[AW-1:0] - AW'(1);
    assign below_idx = count[AW-1:0] - AW'(2);

    always_comb begin
        next_count    = count;
        next_top      = top_q;
        wr_en         = 1'b0;
        wr_idx        = push_idx;
        set_overflow  = 1'b0;
        set_underflow = 1'b0;

        if (clk_en) begin
            if (bus.i_push && bus.i_pop && (count != '0)) begin
                wr_en    = 1'b1;
                wr_idx   = top_idx;
                next_top = bus.i_data;
            end else if (bus.i_push) begin
                if (count != FULL_COUNT) begin
                    wr_en      = 1'b1;
                    wr_idx     = push_idx;
                    next_count = count + CW'(1);
                    next_top   = bus.i_data;
                end else begin
                    set_overflow = 1'b1;
                end
            end else if (bus.i_pop) begin
                if (count != '0) begin
                    next_count = count - CW'(1);
                    next_top   = (count > CW'(1)) ? entries[below_idx] : '0;
                end else begin
                    set_underflow = 1'b1;
                end
            end else if (bus.i_load_enable && (count != '0)) begin
                wr_en    = 1'b1;
                wr_idx   = top_idx;
                next_top = bus.i_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            count     <= '0;
            top_q     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en) begin
                entries[wr_idx] <= bus.i_data;
            end
            count     <= next_count;
            top_q     <= next_top;
            overflow  <= overflow | set_overflow;
            underflow <= underflow | set_underflow;
        end
    end

    assign bus.o_top       = top_q;
    assign bus.o_count     = count;
    assign bus.o_empty     = (count == '0);
    assign bus.o_full      = (count == FULL_COUNT);
    assign bus.o_overflow  = overflow;
    assign bus.o_underflow = underflow;
endmodule

// File: tb/tb_register_stack.sv
// Self-checking bench for register_stack: directed scenarios followed by random
// traffic, all compared against a queue-based LIFO model.
module tb_register_stack;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic clk;
    logic rst;
    logic clk_en;

    register_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    register_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [WIDTH-1:0] model_q [$];
    logic             model_overflow;
    logic             model_underflow;
    int               checks;
    int               errors;

    task automatic compareField(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [WIDTH-1:0] exp_top;
        int               size;
        size    = model_q.size();
        exp_top = (size > 0) ? model_q[size-1] : '0;
        compareField({tag, ".top"},       32'(bus.o_top),       32'(exp_top));
        compareField({tag, ".count"},     32'(bus.o_count),     32'(size));
        compareField({tag, ".empty"},     32'(bus.o_empty),     32'(size == 0));
        compareField({tag, ".full"},      32'(bus.o_full),      32'(size == DEPTH));
        compareField({tag, ".overflow"},  32'(bus.o_overflow),  32'(model_overflow));
        compareField({tag, ".underflow"}, 32'(bus.o_underflow), 32'(model_underflow));
    endtask

    // Stack semantics expressed directly on a queue whose last element is the top.
    task automatic updateModel(input logic r, input logic en, input logic push,
                               input logic pop, input logic load,
                               input logic [WIDTH-1:0] data);
        if (r) begin
            model_q.delete();
            model_overflow  = 1'b0;
            model_underflow = 1'b0;
        end else if (en) begin
            if (push && pop) begin
                if (model_q.size() > 0) model_q[model_q.size()-1] = data;
                else                    model_q.push_back(data);
            end else if (push) begin
                if (model_q.size() < DEPTH) model_q.push_back(data);
                else                        model_overflow = 1'b1;
            end else if (pop) begin
                if (model_q.size() > 0) void'(model_q.pop_back());
                else                    model_underflow = 1'b1;
            end else if (load && model_q.size() > 0) begin
                model_q[model_q.size()-1] = data;
            end
        end
    endtask

    task automatic applyStimulus(input string tag, input logic r, input logic en,
                                 input logic push, input logic pop, input logic load,
                                 input logic [WIDTH-1:0] data);
        rst               = r;
        clk_en            = en;
        bus.i_push        = push;
        bus.i_pop         = pop;
        bus.i_load_enable = load;
        bus.i_data        = data;
        @(posedge clk);
        updateModel(r, en, push, pop, load, data);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        checks            = 0;
        errors            = 0;
        model_overflow    = 1'b0;
        model_underflow   = 1'b0;
        rst               = 1'b1;
        clk_en            = 1'b0;
        bus.i_push        = 1'b0;
        bus.i_pop         = 1'b0;
        bus.i_load_enable = 1'b0;
        bus.i_data        = '0;
        #2;

        // Scenario 1: reset then three pushes.
        applyStimulus("reset", 1, 0, 0, 0, 0, 8'h00);
        applyStimulus("s1.push11", 0, 1, 1, 0, 0, 8'h11);
        applyStimulus("s1.push22", 0, 1, 1, 0, 0, 8'h22);
        applyStimulus("s1.push33", 0, 1, 1, 0, 0, 8'h33);
        compareField("s1.top_literal", 32'(bus.o_top), 32'h33);

        // Scenario 2: fill, then push while full.
        applyStimulus("s2.reset", 1, 1, 0, 0, 0, 8'h00);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus("s2.fill", 0, 1, 1, 0, 0, 8'hA0 + 8'(i));
        end
        applyStimulus("s2.push_full", 0, 1, 1, 0, 0, 8'hFF);
        compareField("s2.top_literal", 32'(bus.o_top), 32'hA3);
        compareField("s2.ovf_literal", 32'(bus.o_overflow), 32'h1);

        // Scenario 3: drain completely, then one extra pop.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus("s3.pop", 0, 1, 0, 1, 0, 8'h00);
        end
        compareField("s3.top_empty_literal", 32'(bus.o_top), 32'h00);
        applyStimulus("s3.pop_empty", 0, 1, 0, 1, 0, 8'h00);
        compareField("s3.unf_literal", 32'(bus.o_underflow), 32'h1);

        // Scenario 4: replace-top and overwrite-top at count 2.
        applyStimulus("s4.reset", 1, 1, 0, 0, 0, 8'h00);
        applyStimulus("s4.push11", 0, 1, 1, 0, 0, 8'h11);
        applyStimulus("s4.push22", 0, 1, 1, 0, 0, 8'h22);
        applyStimulus("s4.replace", 0, 1, 1, 1, 0, 8'h5A);
        compareField("s4.replace_literal", 32'(bus.o_top), 32'h5A);
        applyStimulus("s4.load", 0, 1, 0, 0, 1, 8'h6B);
        compareField("s4.load_literal", 32'(bus.o_top), 32'h6B);
        applyStimulus("s4.load_with_pop", 0, 1, 0, 1, 1, 8'hEE);
        applyStimulus("s4.pop_last", 0, 1, 0, 1, 0, 8'h00);
        applyStimulus("s4.pushpop_empty", 0, 1, 1, 1, 0, 8'h3C);
        applyStimulus("s4.load_empty_prep", 0, 1, 0, 1, 0, 8'h00);
        applyStimulus("s4.load_empty", 0, 1, 0, 0, 1, 8'h99);

        // Scenario 5: clock enable low, random command activity.
        applyStimulus("s5.push", 0, 1, 1, 0, 0, 8'h42);
        for (int i = 0; i < 10; i++) begin
            applyStimulus("s5.hold", 0, 0, 1'($urandom), 1'($urandom),
                          1'($urandom), 8'($urandom));
        end

        // Scenario 6: reset with clock enable low, then a fresh push.
        applyStimulus("s6.push11", 0, 1, 1, 0, 0, 8'h11);
        applyStimulus("s6.push22", 0, 1, 1, 0, 0, 8'h22);
        applyStimulus("s6.reset", 1, 0, 1, 0, 0, 8'h55);
        applyStimulus("s6.push77", 0, 1, 1, 0, 0, 8'h77);
        compareField("s6.top_literal", 32'(bus.o_top), 32'h77);
        compareField("s6.count_literal", 32'(bus.o_count), 32'h1);

        // Random traffic with occasional reset and clock-enable gaps.
        for (int i = 0; i < 400; i++) begin
            applyStimulus("rand", ($urandom_range(0, 49) == 0),
                          ($urandom_range(0, 7) != 0),
                          1'($urandom), 1'($urandom), 1'($urandom),
                          8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
